// File: rtl/midi_pkg.sv
// Shared MIDI constants, launch FSM encodings and status-byte classifiers
// used by the MIDI-out transmit queue.
package midi_pkg;

    localparam logic [7:0] MIDI_STATUS_MIN = 8'h80;
    localparam logic [7:0] MIDI_CHAN_MAX   = 8'hEF;
    localparam logic [7:0] MIDI_SYSCOM_MAX = 8'hF7;
    localparam logic [7:0] MIDI_RT_MIN     = 8'hF8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_BUSY   = 2'd2
    } tx_state_t;

    function automatic logic is_channel_status(input logic [7:0] b);
        return (b >= MIDI_STATUS_MIN) && (b <= MIDI_CHAN_MAX);
    endfunction

    function automatic logic is_system_common(input logic [7:0] b);
        return (b > MIDI_CHAN_MAX) && (b <= MIDI_SYSCOM_MAX);
    endfunction

endpackage

// File: rtl/midi_byte_fifo.sv
// Synchronous byte FIFO with occupancy count; head byte is presented
// combinationally on dout. Pushes while full and pops while empty are ignored.
module midi_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (ADDR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/midi_tx_queue.sv
// MIDI-out byte queue and launch sequencer feeding the UART transmitter.
// Define MIDI_RUNNING_STATUS_EN to drop repeated channel status bytes.
module midi_tx_queue
    import midi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Wr_DV,
    input  logic [7:0]             i_Wr_Byte,
    output logic                   o_Full,
    output logic [$clog2(DEPTH):0] o_Count,
    output logic                   o_Overflow,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic [1:0]             o_State
);

    // Transmitter handshake: o_Tx_DV is a single-cycle launch strobe with
    // o_Tx_Byte valid in that cycle (and held afterwards); a launch only starts
    // while i_Tx_Active=0, and the frame ends on the one-cycle i_Tx_Done pulse.

    tx_state_t  state;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       wr_req;
    logic       wr_accept;
    logic       pop;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status;
    logic       drop;

    assign drop = is_channel_status(i_Wr_Byte) && (i_Wr_Byte == last_status);

    // Last-status only follows bytes that actually entered the queue.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            last_status <= 8'h00;
        end else if (wr_accept) begin
            if (is_channel_status(i_Wr_Byte)) begin
                last_status <= i_Wr_Byte;
            end else if (is_system_common(i_Wr_Byte)) begin
                last_status <= 8'h00;
            end
        end
    end

    assign wr_req = i_Wr_DV && !drop;
`else
    assign wr_req = i_Wr_DV;
`endif

    assign wr_accept = wr_req && !fifo_full;
    assign pop       = (state == S_IDLE) && !fifo_empty && !i_Tx_Active;
    assign o_Full    = fifo_full;
    assign o_State   = state;

    midi_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .push    (wr_accept),
        .pop     (pop),
        .din     (i_Wr_Byte),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_Count)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Overflow <= 1'b0;
        end else begin
            o_Overflow <= wr_req && fifo_full;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
        end else begin
            o_Tx_DV <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        o_Tx_Byte <= fifo_dout;
                        o_Tx_DV   <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: state <= S_BUSY;
                S_BUSY: begin
                    if (i_Tx_Done) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
